// File: rtl/router_1xn.sv
// Single-input, NCH-output byte-serial packet router with per-channel FIFOs.
// Optional per-channel idle-timeout flush is enabled by defining ROUTER_SOFT_RESET_EN.
module router_1xn #(
  parameter int WIDTH   = 8,
  parameter int NCH     = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 pkt_valid,
  input  logic [NCH-1:0]       read_enb,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]       vld_out,
  output logic                 err,
  output logic                 busy
);

  localparam int AW = (NCH > 2) ? $clog2(NCH) : 1;
  localparam int LW = WIDTH - AW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EMPTY,
    S_LOAD,
    S_CHECK,
    S_DROP
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_dest;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_par;
  logic [LW:0]    r_cnt;
  logic [LW-1:0]  r_len;
  logic           r_err;

  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_flush;
  logic [NCH-1:0] w_wr;
  logic [NCH-1:0] w_in_sel;
  logic [NCH-1:0] w_dest_sel;
  logic [WIDTH-1:0] w_wdata;
  logic [AW-1:0]  w_hdr_addr;
  logic           w_in_range;
  logic           w_in_empty;
  logic           w_dest_full;
  logic           w_dest_empty;
  logic           w_dest_flush;

  assign w_hdr_addr = data_in[AW-1:0];
  assign err        = r_err;

  // One-hot decode avoids indexing channel vectors with an out-of-range address.
  always_comb begin
    w_in_sel   = '0;
    w_dest_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_hdr_addr == AW'(i)) w_in_sel[i]   = 1'b1;
      if (r_dest == AW'(i))     w_dest_sel[i] = 1'b1;
    end
  end

  assign w_in_range   = |w_in_sel;
  assign w_in_empty   = |(w_in_sel & w_empty);
  assign w_dest_full  = |(w_dest_sel & w_full);
  assign w_dest_empty = |(w_dest_sel & w_empty);
  assign w_dest_flush = |(w_dest_sel & w_flush);

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = '0;
    w_wdata     = data_in;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pkt_valid) begin
          if (!w_in_range) begin
            w_state_nxt = S_DROP;
          end else if (w_in_empty) begin
            w_wr        = w_in_sel;
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_WAIT_EMPTY;
          end
        end
      end
      S_WAIT_EMPTY: begin
        busy    = 1'b1;
        // The accumulator still holds the latched header at this point.
        w_wdata = r_acc;
        if (w_dest_empty) begin
          w_wr        = w_dest_sel;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy = w_dest_full;
        if (w_dest_flush) begin
          w_state_nxt = (!w_dest_full && !pkt_valid) ? S_IDLE : S_DROP;
        end else if (!w_dest_full) begin
          w_wr = w_dest_sel;
          if (!pkt_valid) w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        if (!pkt_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_dest  <= '0;
      r_acc   <= '0;
      r_par   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (pkt_valid) begin
            r_err  <= 1'b0;
            r_dest <= w_hdr_addr;
            r_len  <= data_in[WIDTH-1:AW];
            r_acc  <= data_in;
            r_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (w_dest_flush) begin
            if (!w_dest_full && !pkt_valid) r_err <= 1'b1;
          end else if (!w_dest_full) begin
            if (pkt_valid) begin
              r_acc <= r_acc ^ data_in;
              // Saturate so an over-long packet cannot wrap back to a matching length.
              if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end else begin
              r_par <= data_in;
            end
          end
        end
        S_CHECK: r_err <= (r_par != r_acc) || (r_cnt != {1'b0, r_len});
        S_DROP:  if (!pkt_valid) r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_empty[g] = (r_count == '0);
    assign w_full[g]  = (r_count == CW'(DEPTH));
    assign w_do_wr    = w_wr[g] && !w_flush[g];
    assign w_do_rd    = read_enb[g] && !w_empty[g] && !w_flush[g];
    assign vld_out[g] = !w_empty[g];
    assign data_out[g*WIDTH +: WIDTH] = r_dout;

    always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wptr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_dout  <= '0;
      end else if (w_flush[g]) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_wr) r_wptr <= r_wptr + 1'b1;
        if (w_do_rd) begin
          r_rptr <= r_rptr + 1'b1;
          r_dout <= r_mem[r_rptr];
        end
        if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
        else if (!w_do_wr && w_do_rd) r_count <= r_count - 1'b1;
      end
    end

`ifdef ROUTER_SOFT_RESET_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmr;

    assign w_flush[g] = !w_empty[g] && !read_enb[g] && (r_tmr == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_tmr <= '0;
      end else if (w_empty[g] || read_enb[g] || w_flush[g]) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
`else
    assign w_flush[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_router_1xn.sv
// Directed self-checking bench for router_1xn at default parameters.
module tb_router_1xn;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  data_in = '0;
  logic        pkt_valid = 1'b0;
  logic [2:0]  read_enb = '0;
  logic [23:0] data_out;
  logic [2:0]  vld_out;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  logic [7:0] expq[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  router_1xn #(.WIDTH(8), .NCH(3), .DEPTH(16), .TIMEOUT(30)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .data_in  (data_in),
    .pkt_valid(pkt_valid),
    .read_enb (read_enb),
    .data_out (data_out),
    .vld_out  (vld_out),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // A pop happens at an edge where read_enb && vld_out; data_out is valid just after it.
  always @(posedge clk) begin : collect
    logic [2:0] taken;
    taken = read_enb & vld_out;
    #1;
    if (taken[0]) q0.push_back(data_out[7:0]);
    if (taken[1]) q1.push_back(data_out[15:8]);
    if (taken[2]) q2.push_back(data_out[23:16]);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic v);
    int w;
    w = 0;
    @(negedge clk);
    data_in   = d;
    pkt_valid = v;
    #1;
    while (busy && w < 200) begin
      stalls++;
      @(negedge clk);
      #1;
      w++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: busy=%b after %0d cycles, required 0", busy, w);
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] seed,
                          input logic [7:0] pmask);
    logic [7:0] par;
    logic [7:0] b;
    par = hdr;
    expq.delete();
    expq.push_back(hdr);
    send_byte(hdr, 1'b1);
    for (int k = 0; k < n; k++) begin
      b   = seed + 8'(k * 13);
      par = par ^ b;
      expq.push_back(b);
      send_byte(b, 1'b1);
    end
    expq.push_back(par ^ pmask);
    send_byte(par ^ pmask, 1'b0);
  endtask

  task automatic wait_q(input int ch, input int n);
    for (int c = 0; c < 200; c++) begin
      if (qsize(ch) >= n) break;
      @(posedge clk);
    end
    #2;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL rst_data_out: got %h, want 000000", data_out); end
    n_checks++; if (vld_out !== 3'b000) begin n_fail++; $display("FAIL rst_vld_out: got %b, want 000", vld_out); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, want 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, want 0", busy); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_ch0_stream;
    q0.delete();
    stalls   = 0;
    read_enb = '0;
    fork
      send_pkt(8'h48, 18, 8'h11, 8'h00);
      begin #250; read_enb[0] = 1'b1; end
    join
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ch0_err: got %b, want 0", err); end
    wait_q(0, 20);
    n_checks++; if (q0.size() !== 20) begin n_fail++; $display("FAIL ch0_count: got %0d, want 20", q0.size()); end
    for (int k = 0; k < expq.size() && k < q0.size(); k++) begin
      n_checks++;
      if (q0[k] !== expq[k]) begin n_fail++; $display("FAIL ch0_data[%0d]: got %h, want %h", k, q0[k], expq[k]); end
    end
    n_checks++; if (stalls == 0) begin n_fail++; $display("FAIL ch0_stall: got %0d stall cycles, want >0", stalls); end
    read_enb = '0;
  endtask

  task automatic test_ch1_full;
    q1.delete();
    stalls   = 0;
    read_enb = '0;
    send_pkt(8'h39, 14, 8'h20, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL ch1_stall: got %0d stall cycles, want 0", stalls); end
    n_checks++; if (vld_out[1] !== 1'b1) begin n_fail++; $display("FAIL ch1_vld: got %b, want 1", vld_out[1]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ch1_busy_idle: got %b, want 0", busy); end
    repeat (40) @(posedge clk);
    #1;
`ifdef ROUTER_SOFT_RESET_EN
    n_checks++; if (vld_out[1] !== 1'b0) begin n_fail++; $display("FAIL ch1_timeout_vld: got %b, want 0", vld_out[1]); end
`else
    n_checks++; if (vld_out[1] !== 1'b1) begin n_fail++; $display("FAIL ch1_hold_vld: got %b, want 1", vld_out[1]); end
    read_enb[1] = 1'b1;
    wait_q(1, 16);
    repeat (3) @(posedge clk);
    #1;
    read_enb = '0;
    n_checks++; if (q1.size() !== 16) begin n_fail++; $display("FAIL ch1_count: got %0d, want 16", q1.size()); end
    for (int k = 0; k < expq.size() && k < q1.size(); k++) begin
      n_checks++;
      if (q1[k] !== expq[k]) begin n_fail++; $display("FAIL ch1_data[%0d]: got %h, want %h", k, q1[k], expq[k]); end
    end
    n_checks++; if (vld_out[1] !== 1'b0) begin n_fail++; $display("FAIL ch1_drained_vld: got %b, want 0", vld_out[1]); end
`endif
  endtask

  task automatic test_ch2_backpressure;
    q2.delete();
    stalls   = 0;
    read_enb = '0;
    fork
      send_pkt(8'h66, 25, 8'h5A, 8'h00);
      begin repeat (20) @(negedge clk); read_enb[2] = 1'b1; end
    join
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ch2_err: got %b, want 0", err); end
    wait_q(2, 27);
    n_checks++; if (q2.size() !== 27) begin n_fail++; $display("FAIL ch2_count: got %0d, want 27", q2.size()); end
    for (int k = 0; k < expq.size() && k < q2.size(); k++) begin
      n_checks++;
      if (q2[k] !== expq[k]) begin n_fail++; $display("FAIL ch2_data[%0d]: got %h, want %h", k, q2[k], expq[k]); end
    end
    n_checks++; if (stalls == 0) begin n_fail++; $display("FAIL ch2_stall: got %0d stall cycles, want >0", stalls); end
    read_enb = '0;
  endtask

  task automatic test_parity_err;
    read_enb = '1;
    send_pkt(8'h0C, 3, 8'h33, 8'h01);
    @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_in_check: got %b, want 0", err); end
    @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b, want 1", err); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL perr_hold: got %b, want 1", err); end
    send_byte(8'h04, 1'b1);
    @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_clear: got %b, want 0", err); end
    send_byte(8'hA5, 1'b1);
    send_byte(8'hA1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL perr_good_pkt: got %b, want 0", err); end
    repeat (6) @(posedge clk);
    read_enb = '0;
  endtask

  task automatic test_drop;
    read_enb = '0;
    stalls   = 0;
    repeat (3) @(posedge clk);
    send_pkt(8'h0B, 2, 8'h44, 8'h00);
    @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b, want 1", err); end
    n_checks++; if (vld_out !== 3'b000) begin n_fail++; $display("FAIL drop_vld: got %b, want 000", vld_out); end
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL drop_stall: got %0d stall cycles, want 0", stalls); end
  endtask

  task automatic test_reset_midpkt;
    read_enb = '0;
    send_byte(8'h48, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(8'h70 + 8'(k), 1'b1);
    @(posedge clk);
    #1;
    n_checks++; if (vld_out !== 3'b001) begin n_fail++; $display("FAIL mid_vld_pre: got %b, want 001", vld_out); end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL mid_rst_data_out: got %h, want 000000", data_out); end
    n_checks++; if (vld_out !== 3'b000) begin n_fail++; $display("FAIL mid_rst_vld: got %b, want 000", vld_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b, want 0", err); end
    pkt_valid = 1'b0;
    data_in   = '0;
    @(negedge clk);
    resetn = 1'b1;
    q0.delete();
    read_enb[0] = 1'b1;
    send_pkt(8'h0C, 3, 8'h90, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_after_err: got %b, want 0", err); end
    wait_q(0, 5);
    n_checks++; if (q0.size() !== 5) begin n_fail++; $display("FAIL mid_after_count: got %0d, want 5", q0.size()); end
    for (int k = 0; k < expq.size() && k < q0.size(); k++) begin
      n_checks++;
      if (q0[k] !== expq[k]) begin n_fail++; $display("FAIL mid_after_data[%0d]: got %h, want %h", k, q0[k], expq[k]); end
    end
    read_enb = '0;
  endtask

  initial begin
    test_reset();
    test_ch0_stream();
    test_ch1_full();
    test_ch2_backpressure();
    test_parity_err();
    test_drop();
    test_reset_midpkt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
